// File: rtl/add_pkg.sv
// add_pkg: shared widths and request/response records for the fp32 add-cluster normalizer.
// No ports; holds default widths plus the norm_req_t / norm_rsp_t records at those widths.
package add_pkg;
    localparam int MANT_W_DEF  = 47;
    localparam int EXP_W_DEF   = 8;
    localparam int NUM_REQ_DEF = 2;
    localparam int ID_W_DEF    = 1;

    typedef struct packed {
        logic [MANT_W_DEF-1:0] mant;
        logic [EXP_W_DEF-1:0]  exp;
    } norm_req_t;

    typedef struct packed {
        logic [ID_W_DEF-1:0]   id;
        logic [MANT_W_DEF-1:0] mant;
        logic [EXP_W_DEF-1:0]  exp;
        logic                  zero;
        logic                  uflow;
    } norm_rsp_t;
endpackage

// File: rtl/add_lod.sv
// add_lod: leading-one detector with normalizing left shift.
// Ports: mant (in, W) operand; lz (out, LZ_W) leading-zero count; norm (out, W) mant shifted so its MSB is the leading one.
// lz is meaningless for an all-zero operand (norm is then zero).
module add_lod #(
    parameter int W = 47,
    localparam int LZ_W = $clog2(W)
) (
    input  logic [W-1:0]    mant,
    output logic [LZ_W-1:0] lz,
    output logic [W-1:0]    norm
);
    // Greedy log shifter: at each power-of-two stage, shift if the top 2^s bits are all zero.
    always_comb begin
        norm = mant;
        lz   = '0;
        for (int s = LZ_W - 1; s >= 0; s--) begin
            lz[s] = (norm & ~({W{1'b1}} >> (1 << s))) == '0;
            norm  = lz[s] ? norm << (1 << s) : norm;
        end
    end
endmodule

// File: rtl/add_norm_sched.sv
// add_norm_sched: round-robin arbiter feeding a shared 2-stage normalizer pipeline.
// Ports: clk, rst_n (async, active-low); req_valid/req_ready/req_mant/req_exp per lane (flattened);
// rsp_valid/rsp_ready handshake with rsp_id, rsp_mant, rsp_exp, rsp_zero, rsp_uflow results.
module add_norm_sched
    import add_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int MANT_W  = MANT_W_DEF,
    parameter int EXP_W   = EXP_W_DEF,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int LZ_W   = $clog2(MANT_W)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*MANT_W-1:0] req_mant,
    input  logic [NUM_REQ*EXP_W-1:0]  req_exp,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [MANT_W-1:0]         rsp_mant,
    output logic [EXP_W-1:0]          rsp_exp,
    output logic                      rsp_zero,
    output logic                      rsp_uflow
);
    logic [ID_W-1:0]   rr_ptr, gnt_id, s1_id;
    logic              gnt_any, s1_valid, s1_free, s2_adv, hs;
    logic [MANT_W-1:0] s1_mant, norm;
    logic [EXP_W-1:0]  s1_exp;
    logic [LZ_W-1:0]   lz;
    logic [EXP_W:0]    diff;
    logic              s1_zero, s1_uflow;

    // Scan from rr_ptr upward; iterating downward lets the lane nearest rr_ptr win.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign s2_adv    = !rsp_valid || rsp_ready;
    assign s1_free   = !s1_valid || s2_adv;
    // rst_n gating keeps req_ready low while reset is held.
    assign hs        = rst_n && gnt_any && s1_free;
    assign req_ready = hs ? (NUM_REQ'(1) << gnt_id) : '0;

    add_lod #(.W(MANT_W)) u_lod (
        .mant (s1_mant),
        .lz   (lz),
        .norm (norm)
    );

    // One extra bit so exp <= lz shows up as a negative or zero difference.
    assign diff     = {1'b0, s1_exp} - (EXP_W+1)'(lz);
    assign s1_zero  = s1_mant == '0;
    assign s1_uflow = !s1_zero && (diff[EXP_W] || diff == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            s1_mant   <= '0;
            s1_exp    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_mant  <= '0;
            rsp_exp   <= '0;
            rsp_zero  <= 1'b0;
            rsp_uflow <= 1'b0;
        end else begin
            if (hs) begin
                rr_ptr  <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
                s1_id   <= gnt_id;
                s1_mant <= req_mant[gnt_id*MANT_W +: MANT_W];
                s1_exp  <= req_exp[gnt_id*EXP_W +: EXP_W];
            end
            if (s1_free) s1_valid <= hs;
            if (s2_adv) rsp_valid <= s1_valid;
            if (s2_adv && s1_valid) begin
                rsp_id    <= s1_id;
                rsp_mant  <= s1_zero ? '0 : norm;
                rsp_exp   <= (s1_zero || s1_uflow) ? '0 : diff[EXP_W-1:0];
                rsp_zero  <= s1_zero;
                rsp_uflow <= s1_uflow;
            end
        end
    end
endmodule
